// File: rtl/pixel_stream_buffer.sv
// pixel_stream_buffer
//   Elastic 24-bit pixel buffer between the memory-side pixel fetch path and
//   the DVI Video/VideoReady/VideoValid interface, single clock (cpu_clk_g).
//   A first-word-fall-through FIFO holds pixels. Raster position is tracked per
//   transfer. A one-cycle frame_interrupt follows the last pixel of a frame.
//   refill_req signals a low buffer.
//
//   Optional feature (define to enable): PIXBUF_UNDERRUN_FILL_EN
//     When enabled, video_valid is held high. An empty FIFO presents FILL_COLOR,
//     and that fill pixel counts as a raster transfer, which keeps the DVI
//     timing aligned through memory stalls.
//
//   Ports
//     clk              clock (cpu_clk_g domain)
//     rst              synchronous active-high reset
//     in_data/in_valid pixel word input, [23:0] RGB, [31:24] ignored
//     in_ready         buffer can accept (~full & ~rst)
//     video            pixel to DVI
//     video_valid      pixel valid
//     video_ready      DVI accepts pixel this cycle
//     level            FIFO occupancy 0..DEPTH
//     refill_req       registered, level <= LOW_WATER (previous cycle)
//     pix_x/pix_y      raster position of the pixel currently at video
//     frame_interrupt  one-cycle pulse after the final pixel of a frame
//     underrun_count   saturating count of ready-while-empty cycles
module pixel_stream_buffer #(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned H_PIXELS   = 800,
  parameter int unsigned V_LINES    = 600,
  parameter int unsigned LOW_WATER  = 16,
  parameter logic [23:0] FILL_COLOR = 24'h000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [23:0]       video,
  output logic              video_valid,
  input  logic              video_ready,
  output logic [ADDR_W:0]   level,
  output logic              refill_req,
  output logic [10:0]       pix_x,
  output logic [9:0]        pix_y,
  output logic              frame_interrupt,
  output logic [15:0]       underrun_count
);

  localparam int unsigned     DEPTH      = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LOW_LEVEL  = (ADDR_W + 1)'(LOW_WATER);
  localparam logic [10:0]     X_LAST     = 11'(H_PIXELS - 1);
  localparam logic [9:0]      Y_LAST     = 10'(V_LINES - 1);

  logic [23:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   level_q;

  logic empty;
  logic full;
  logic wr_en;
  logic pop;
  logic xfer;
  logic underrun;
  logic last_x;
  logic last_y;

  // Upper byte of the input word carries no pixel data.
  logic unused_hi;
  assign unused_hi = ^in_data[31:24];

  assign empty    = (level_q == '0);
  assign full     = (level_q == FULL_LEVEL);
  assign in_ready = ~full & ~rst;
  assign wr_en    = in_valid & in_ready;

`ifdef PIXBUF_UNDERRUN_FILL_EN
  assign video_valid = 1'b1;
  assign video       = empty ? FILL_COLOR : mem[rd_ptr];
`else
  logic unused_fill;
  assign unused_fill = ^FILL_COLOR;
  assign video_valid = ~empty;
  assign video       = empty ? '0 : mem[rd_ptr];
`endif

  // A fill pixel is a transfer for the raster but never pops the FIFO.
  assign xfer     = video_valid & video_ready;
  assign pop      = xfer & ~empty;
  assign underrun = video_ready & empty;
  assign last_x   = (pix_x == X_LAST);
  assign last_y   = (pix_y == Y_LAST);

  assign level = level_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= in_data[23:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + ADDR_W'(1);
      unique case ({wr_en, pop})
        2'b10:   level_q <= level_q + (ADDR_W + 1)'(1);
        2'b01:   level_q <= level_q - (ADDR_W + 1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_x           <= '0;
      pix_y           <= '0;
      frame_interrupt <= 1'b0;
    end else begin
      frame_interrupt <= xfer & last_x & last_y;
      if (xfer) begin
        if (last_x) begin
          pix_x <= '0;
          pix_y <= last_y ? '0 : pix_y + 10'd1;
        end else begin
          pix_x <= pix_x + 11'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_count <= '0;
      refill_req     <= 1'b1;
    end else begin
      if (underrun && underrun_count != '1) begin
        underrun_count <= underrun_count + 16'd1;
      end
      refill_req <= (level_q <= LOW_LEVEL);
    end
  end

endmodule

// File: tb/tb_pixel_stream_buffer.sv
// Directed bench for pixel_stream_buffer (default build, fill feature off).
// The raster is shrunk to 20x5 so that frame wraps happen within a short run.
module tb_pixel_stream_buffer;

  localparam int unsigned HP = 20;
  localparam int unsigned VL = 5;
  localparam int unsigned FRAME = HP * VL;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] video;
  logic        video_valid;
  logic        video_ready;
  logic [6:0]  level;
  logic        refill_req;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;
  logic        frame_interrupt;
  logic [15:0] underrun_count;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  pixel_stream_buffer #(
    .ADDR_W    (6),
    .H_PIXELS  (HP),
    .V_LINES   (VL),
    .LOW_WATER (16),
    .FILL_COLOR(24'h000000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .video          (video),
    .video_valid    (video_valid),
    .video_ready    (video_ready),
    .level          (level),
    .refill_req     (refill_req),
    .pix_x          (pix_x),
    .pix_y          (pix_y),
    .frame_interrupt(frame_interrupt),
    .underrun_count (underrun_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int unsigned next_wr;
    int unsigned exp_rd;
    int unsigned ntx;
    int unsigned pulses;
    int unsigned cyc;
    logic        acc;
    logic        t;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; video_ready = 1'b0;
    step();
    chk("in_ready_during_rst", 32'(in_ready), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_video_valid", 32'(video_valid), 32'd0);
    chk("rst_refill", 32'(refill_req), 32'd1);
    chk("rst_pix_x", 32'(pix_x), 32'd0);
    chk("rst_pix_y", 32'(pix_y), 32'd0);
    chk("rst_frame_irq", 32'(frame_interrupt), 32'd0);
    chk("rst_underrun", 32'(underrun_count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Fill to full with video_ready low; upper byte carries junk.
    for (int i = 1; i <= 64; i++) begin
      in_data  = 32'hAB000000 | 32'(i);
      in_valid = 1'b1;
      step();
      if (i == 1) begin
        chk("first_word_video_valid", 32'(video_valid), 32'd1);
        chk("first_word_video", 32'(video), 32'h000001);
      end
      if (i == 17) begin
        chk("lvl17_level", 32'(level), 32'd17);
        chk("lvl17_refill_lag", 32'(refill_req), 32'd1);
      end
      if (i == 18) chk("lvl18_refill_low", 32'(refill_req), 32'd0);
    end
    chk("full_level", 32'(level), 32'd64);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_video", 32'(video), 32'h000001);
    in_data = 32'd65;
    step();
    chk("word65_rejected_level", 32'(level), 32'd64);
    chk("word65_rejected_video", 32'(video), 32'h000001);

    // Drain from full while writing continuously; pointers wrap past 64.
    video_ready = 1'b1;
    next_wr = 65;
    exp_rd  = 1;
    for (int c = 0; c < 80; c++) begin
      chk("drain_video", 32'(video), 32'(exp_rd));
      chk("drain_video_valid", 32'(video_valid), 32'd1);
      in_data = 32'(next_wr);
      acc = in_ready;
      if (c == 0) chk("drain_first_in_ready", 32'(acc), 32'd0);
      step();
      exp_rd++;
      if (acc) next_wr++;
      chk("drain_level", 32'(level), 32'd63);
      chk("drain_in_ready", 32'(in_ready), 32'd1);
      chk("drain_no_irq", 32'(frame_interrupt), 32'd0);
    end
    chk("drain_pix_x", 32'(pix_x), 32'd0);
    chk("drain_pix_y", 32'(pix_y), 32'd4);
    video_ready = 1'b0;
    in_valid    = 1'b0;

    // Continuous stream through one and a half frames.
    rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b1; video_ready = 1'b1;
    ntx = 0; pulses = 0; cyc = 0; next_wr = 1;
    while (ntx < 150 && cyc < 400) begin
      t = video_valid;
      in_data = 32'(next_wr);
      step();
      next_wr++;
      cyc++;
      if (t) ntx++;
      if (frame_interrupt) pulses++;
      chk("frame_irq", 32'(frame_interrupt), 32'(t && (ntx % FRAME == 0)));
      chk("frame_pix_x", 32'(pix_x), 32'(ntx % HP));
      chk("frame_pix_y", 32'(pix_y), 32'((ntx / HP) % VL));
    end
    chk("frame_transfers_done", ntx, 32'd150);
    chk("frame_pulse_count", pulses, 32'd1);

    // Underrun counting and saturation.
    in_valid = 1'b0; video_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    video_ready = 1'b1;
    repeat (10) step();
    chk("under10_video_valid", 32'(video_valid), 32'd0);
    chk("under10_count", 32'(underrun_count), 32'd10);
    chk("under10_pix_x", 32'(pix_x), 32'd0);
    chk("under10_level", 32'(level), 32'd0);
    repeat (32'hFFFE - 10) step();
    chk("under_fffe", 32'(underrun_count), 32'hFFFE);
    repeat (3) step();
    chk("under_saturate", 32'(underrun_count), 32'hFFFF);

    // Mid-frame reset lands on what would have been the frame's last transfer.
    video_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 32'(i + 1);
      step();
    end
    chk("fill20_level", 32'(level), 32'd20);
    chk("fill20_refill", 32'(refill_req), 32'd0);
    video_ready = 1'b1;
    for (int i = 0; i < 99; i++) begin
      in_data = 32'(i + 21);
      step();
    end
    chk("pre_rst_level", 32'(level), 32'd20);
    chk("pre_rst_pix_x", 32'(pix_x), 32'd19);
    chk("pre_rst_pix_y", 32'(pix_y), 32'd4);
    rst = 1'b1;
    step();
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_pix_x", 32'(pix_x), 32'd0);
    chk("midrst_pix_y", 32'(pix_y), 32'd0);
    chk("midrst_video_valid", 32'(video_valid), 32'd0);
    chk("midrst_refill", 32'(refill_req), 32'd1);
    chk("midrst_frame_irq", 32'(frame_interrupt), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0; in_valid = 1'b0; video_ready = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_stream_buffer.md
# pixel_stream_buffer

Elastic pixel buffer between the memory-side pixel fetch path and the DVI 24-bit Video/VideoReady/VideoValid interface, in the cpu_clk_g domain. Accepts 32-bit pixel words (low 24 bits are RGB), buffers them in a FIFO, and presents them to the DVI consumer. Tracks raster position, raises a one-cycle frame_interrupt to the CPU at end of frame, and requests refill when the buffer runs low.

## Interface
Parameters:
- ADDR_W, 6: FIFO address width; DEPTH = 2**ADDR_W = 64 entries.
- H_PIXELS, 800: visible pixels per line.
- V_LINES, 600: visible lines per frame.
- LOW_WATER, 16: refill_req threshold, 0..DEPTH-1.
- FILL_COLOR, 24'h000000: pixel driven on underrun when fill is compiled in.

Ports:
- clk  in  1  cpu_clk_g domain clock; single clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  32  pixel word; [23:0] RGB, [31:24] ignored.
- in_valid  in  1  in_data valid.
- in_ready  out  1  buffer can accept; = ~full & ~rst.
- video  out  24  pixel to DVI.
- video_valid  out  1  video valid.
- video_ready  in  1  DVI accepts pixel this cycle.
- level  out  ADDR_W+1  current FIFO occupancy, 0..DEPTH.
- refill_req  out  1  registered; 1 when level <= LOW_WATER.
- pix_x  out  11  column of the pixel currently at video.
- pix_y  out  10  line of the pixel currently at video.
- frame_interrupt  out  1  one-cycle pulse after the last pixel of a frame transfers.
- underrun_count  out  16  saturating count of underrun cycles.

## Operation
- FIFO: DEPTH entries × 24 bits, first-word-fall-through. Write on in_valid & in_ready. Read on pop = video_valid & video_ready & ~empty.
- video = head entry [23:0]. video_valid = ~empty. Both are undefined/0 and 0 respectively when empty.
- Full when level == DEPTH. in_ready = 0 when full, even if a pop occurs that cycle; there is no same-cycle pass-through.
- Simultaneous write and pop with 0 < level < DEPTH: level unchanged.
- level updates as +1 on write only, −1 on pop only, unchanged on both or neither.
- Pointers are ADDR_W bits and wrap naturally at DEPTH.
- Raster counters advance on every transfer, defined as video_valid & video_ready.
  - pix_x increments; at H_PIXELS-1, pix_x wraps to 0 and pix_y increments.
  - At pix_x = H_PIXELS-1 and pix_y = V_LINES-1, both wrap to 0 and frame_interrupt is 1 on the next cycle only.
- Underrun: a cycle with video_ready = 1 and the FIFO empty. On underrun, underrun_count increments and saturates at 16'hFFFF.
- Reset: all of the following take effect in the cycle after rst is sampled high.
  - Pointers, level, pix_x, pix_y, frame_interrupt and underrun_count go to 0.
  - video_valid goes to 0 without fill, 1 with fill.
  - refill_req goes to 1.
  - FIFO contents are discarded. Asserting rst mid-frame drops buffered pixels and restarts the raster at (0,0) with no frame_interrupt.

## Timing
- Write-to-output latency is 1 cycle: a word accepted at edge N into an empty FIFO shows video_valid = 1 with that pixel after edge N.
- in_ready is combinational from the registered level and rst.
- refill_req reflects level as of the previous cycle, so its lag is 1 cycle.
- frame_interrupt is asserted exactly 1 cycle after the edge on which the final pixel transfers.
- Throughput is 1 pixel/cycle both sides when 0 < level < DEPTH.

## Configuration
- PIXBUF_UNDERRUN_FILL_EN defined:
  - video_valid is constantly 1 out of reset.
  - When empty, video = FILL_COLOR.
  - A fill pixel accepted by video_ready counts as a transfer: it advances pix_x/pix_y and can trigger frame_interrupt.
  - The fill pixel still increments underrun_count. No FIFO pop occurs.
  - Keeps the DVI raster aligned through memory stalls.
- PIXBUF_UNDERRUN_FILL_EN undefined:
  - video_valid = ~empty.
  - Empty cycles do not move the raster.
  - underrun_count still increments on video_ready & empty.

## Test plan
- Reset, then hold video_ready = 0 and push 64 words 0x00000001..0x00000040: in_ready falls after the 64th accept, level = 64, the 65th word is not accepted, refill_req = 0 one cycle later.
- From full, video_ready = 1 and in_valid = 1 continuously: video outputs 0x000001, 0x000002, … in order. With simultaneous write and pop at level 63, level stays 63. After the initial full drain cycle, in_ready toggles correctly.
- Stream 480000 pixels with H_PIXELS = 800, V_LINES = 600: frame_interrupt pulses exactly once, one cycle after transfer 480000; pix_x/pix_y read (0,0) afterwards. No pulse occurs at transfer 800.
- Empty FIFO, video_ready = 1 for 10 cycles:
  - Without the macro: video_valid = 0, underrun_count = 10, pix_x unchanged.
  - With the macro: video = 000000, pix_x = 10, underrun_count = 10.
- Set underrun_count to 0xFFFE via 0xFFFE empty ready cycles, then 3 more: underrun_count holds 0xFFFF.
- Fill 20 words, transfer 300 pixels, assert rst 1 cycle: next cycle level = 0, pix_x = 0, pix_y = 0, video_valid = 0 (no macro), refill_req = 1, frame_interrupt = 0.
